// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the two-digit BCD seven-segment counter.
//
// Contents:
//   bcd_t      - one BCD digit (legal values 0..9, codes 10..15 unused)
//   seg7_t     - one active-low seven-segment field, bit order a..g MSB..LSB
//   SEG_BLANK  - all segments dark
//   SEG_DIGIT  - glyph table for digits 0..9
package bcd_seg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  // Active-low: a 0 bit lights the segment.
  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment decoder, purely combinational.
//
// Ports:
//   bcd      in  4  BCD digit to display
//   blank_en in  1  force the field dark (used for leading-zero blanking)
//   seg      out 7  segment pattern, a..g MSB..LSB, 0 = lit
//
// Codes 10..15 never come out of the counter; if they ever appear the
// field goes dark rather than showing a garbage pattern.
module seg7_decoder
  import bcd_seg_pkg::*;
(
  input  bcd_t  bcd,
  input  logic  blank_en,
  output seg7_t seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank_en) begin
      case (bcd)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_counter.sv
// Free-running two-digit BCD up-counter (0..MAX_COUNT) driving an
// active-low two-digit seven-segment display bus.
//
// Parameters:
//   MAX_COUNT  terminal count, legal 1..99 (default 99)
//
// Ports:
//   clk     in   1   system clock, state updates on rising edge
//   rst     in   1   asynchronous active-high reset, priority over clk
//   result  out  14  [13:7] tens segments, [6:0] units segments
//
// Build option:
//   BCD_SEG_COUNTER_SATURATE_EN  when defined the counter holds at
//   MAX_COUNT until reset; otherwise (default) it wraps to 0.
//
// result is decoded combinationally from the count registers, so it
// changes in the same cycle as the count. The tens field is blanked
// while tens is 0 (leading-zero suppression); units always shows.
module bcd_seg_counter
  import bcd_seg_pkg::*;
#(
  parameter int MAX_COUNT = 99
) (
  input  logic        clk,
  input  logic        rst,
  output logic [13:0] result
);

  localparam bcd_t MAX_TENS  = bcd_t'(MAX_COUNT / 10);
  localparam bcd_t MAX_UNITS = bcd_t'(MAX_COUNT % 10);

  bcd_t  tens;
  bcd_t  units;
  logic  at_max;
  seg7_t tens_seg;
  seg7_t units_seg;

  assign at_max = (tens == MAX_TENS) && (units == MAX_UNITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (at_max) begin
`ifdef BCD_SEG_COUNTER_SATURATE_EN
      tens  <= tens;
      units <= units;
`else
      tens  <= 4'd0;
      units <= 4'd0;
`endif
    end else if (units == 4'd9) begin
      // Decimal carry from units into tens.
      units <= 4'd0;
      tens  <= tens + 4'd1;
    end else begin
      units <= units + 4'd1;
    end
  end

  seg7_decoder u_tens_dec (
    .bcd      (tens),
    .blank_en (tens == 4'd0),
    .seg      (tens_seg)
  );

  seg7_decoder u_units_dec (
    .bcd      (units),
    .blank_en (1'b0),
    .seg      (units_seg)
  );

  assign result = {tens_seg, units_seg};

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Testbench for bcd_seg_counter: table of {edges-from-reset, expected
// display} vectors, a per-edge scoreboard fed by an independent count
// model, and hand-written sequences for reset priority and mid-count
// reset. MAX_COUNT is 99 in the default build, 12 with the saturate
// option so the hold behaviour is reachable quickly.
module tb_bcd_seg_counter;

`ifdef BCD_SEG_COUNTER_SATURATE_EN
  localparam int  MAXC = 12;
  localparam bit  SAT  = 1'b1;
`else
  localparam int  MAXC = 99;
  localparam bit  SAT  = 1'b0;
`endif

  localparam logic [13:0] D_RST   = 14'b1111111_0000001;
  localparam logic [13:0] D_ONE   = 14'b1111111_1001111;
  localparam logic [13:0] D_TWO   = 14'b1111111_0010010;
  localparam logic [13:0] D_THREE = 14'b1111111_0000110;
  localparam logic [13:0] D_NINE  = 14'b1111111_0000100;
  localparam logic [13:0] D_TEN   = 14'b1001111_0000001;
  localparam logic [13:0] D_TWLV  = 14'b1001111_0010010;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] result;

  bcd_seg_counter #(.MAX_COUNT(MAXC)) dut (
    .clk    (clk),
    .rst    (rst),
    .result (result)
  );

  // ---------------- reference model ----------------
  logic [6:0] glyph [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  int model_cnt = 0;

  function automatic logic [13:0] enc(input int c);
    int t;
    int u;
    logic [6:0] tf;
    t  = c / 10;
    u  = c % 10;
    tf = (t == 0) ? 7'b1111111 : glyph[t];
    return {tf, glyph[u]};
  endfunction

  function automatic int next_cnt(input int c);
    if (c == MAXC) return SAT ? c : 0;
    return c + 1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One full clock cycle; ends with clk low so result is sampled away
  // from the rising edge.
  task automatic tick(input string name);
    logic [13:0] e;
    if (!rst) model_cnt = next_cnt(model_cnt);
    else      model_cnt = 0;
    exp_q.push_back(enc(model_cnt));
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
    e = exp_q.pop_front();
    check(name, result, e);
  endtask

  // Assert reset with the clock parked low: display must clear without
  // any edge.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #2;
    model_cnt = 0;
    check(name, result, D_RST);
    rst = 1'b0;
    #2;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    int          edges;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int target;

    vecs[0] = '{"reset_only", 0,   D_RST};
    vecs[1] = '{"one_edge",   1,   D_ONE};
    vecs[2] = '{"two_edges",  2,   D_TWO};
    vecs[3] = '{"three_edge", 3,   D_THREE};
    vecs[4] = '{"nine_blank", 9,   D_NINE};
    vecs[5] = '{"ten_carry",  10,  D_TEN};
    vecs[6] = '{"hundred",    100, SAT ? D_TWLV : D_RST};

    #3;
    for (int i = 0; i < 7; i++) begin
      do_reset({vecs[i].name, "_rst"});
      for (int k = 0; k < vecs[i].edges; k++) tick({vecs[i].name, "_edge"});
      check({vecs[i].name, "_final"}, result, vecs[i].exp);
    end

    // Reset held while clk toggles: rst wins, count stays 0.
    do_reset("prio_rst");
    rst = 1'b1;
    tick("prio_hold");
    tick("prio_hold");
    rst = 1'b0;
    #2;
    tick("prio_release");
    check("prio_release_one", result, D_ONE);

    // Mid-count reset between edges.
    target = (MAXC >= 57) ? 57 : 7;
    do_reset("mid_rst0");
    for (int k = 0; k < target; k++) tick("mid_count");
    check("mid_value", result, enc(target));
    #2 rst = 1'b1;
    #1;
    model_cnt = 0;
    check("mid_async_clear", result, D_RST);
    rst = 1'b0;
    #2;
    tick("mid_after");
    check("mid_after_one", result, D_ONE);

    // Terminal-count boundary: step right up to MAXC, then one more edge.
    do_reset("term_rst");
    for (int k = 0; k < MAXC; k++) tick("term_count");
    check("term_at_max", result, enc(MAXC));
    tick("term_next");
    check("term_after_max", result, SAT ? enc(MAXC) : D_RST);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
